// File: rtl/adder8_bist_ctrl.sv
// LFSR-driven self-test controller for the 8-bit select adder: drives operands, waits, checks {co,s}.
// Define FIRST_FAIL_CAPTURE_EN to add the first-mismatch capture outputs (fail_*).
module adder8_bist_ctrl #(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter logic [16:0] SEED          = 17'h1_0A05,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [7:0]       dut_a,
  output logic [7:0]       dut_b,
  output logic             dut_ci,
  input  logic [7:0]       dut_s,
  input  logic             dut_co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [7:0]       fail_a,
  output logic [7:0]       fail_b,
  output logic             fail_ci,
  output logic [7:0]       fail_s,
  output logic             fail_co
`endif
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [16:0] SEED_EFF = (SEED == 17'd0) ? 17'd1 : SEED;
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE   = 4'(SETTLE_CYCLES);

  state_t             state_reg, state_next;
  logic [16:0]        lfsr_reg;
  logic [15:0]        vec_cnt_reg;
  logic [3:0]         settle_reg;
  logic [ERR_W-1:0]   err_count_reg;
  logic [7:0]         a_reg, b_reg;
  logic               ci_reg;
  logic               armed_reg;
  logic               start_ok;
  logic [8:0]         expected;
  logic               mismatch;

  // armed_reg blocks a start sampled on the first edge after reset release
  assign start_ok = start & armed_reg;
  assign expected = {1'b0, a_reg} + {1'b0, b_reg} + {8'd0, ci_reg};
  assign mismatch = ({dut_co, dut_s} != expected);

  assign dut_a     = a_reg;
  assign dut_b     = b_reg;
  assign dut_ci    = ci_reg;
  assign busy      = (state_reg == DRIVE) || (state_reg == WAIT) || (state_reg == CHECK);
  assign done      = (state_reg == DONE);
  assign pass      = done && (err_count_reg == '0);
  assign err_count = err_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start_ok) state_next = DRIVE;
      DRIVE:      state_next = (SETTLE == 4'd0) ? CHECK : WAIT;
      WAIT:       if (settle_reg <= 4'd1) state_next = CHECK;
      CHECK:      state_next = (vec_cnt_reg == LAST_VEC) ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg      <= '0;
      vec_cnt_reg   <= '0;
      settle_reg    <= '0;
      err_count_reg <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      ci_reg        <= 1'b0;
      armed_reg     <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_ci    <= 1'b0;
      fail_s     <= '0;
      fail_co    <= 1'b0;
`endif
    end else begin
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE, DONE: begin
          if (start_ok) begin
            lfsr_reg      <= SEED_EFF;
            vec_cnt_reg   <= '0;
            err_count_reg <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_ci    <= 1'b0;
            fail_s     <= '0;
            fail_co    <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          a_reg      <= lfsr_reg[7:0];
          b_reg      <= lfsr_reg[15:8];
          ci_reg     <= lfsr_reg[16];
          settle_reg <= SETTLE;
        end
        WAIT: settle_reg <= settle_reg - 4'd1;
        CHECK: begin
          if (mismatch && (err_count_reg != {ERR_W{1'b1}}))
            err_count_reg <= err_count_reg + 1'b1;
          lfsr_reg <= {lfsr_reg[15:0], lfsr_reg[16] ^ lfsr_reg[13]};
          if (vec_cnt_reg != LAST_VEC)
            vec_cnt_reg <= vec_cnt_reg + 16'd1;
`ifdef FIRST_FAIL_CAPTURE_EN
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a_reg;
            fail_b     <= b_reg;
            fail_ci    <= ci_reg;
            fail_s     <= dut_s;
            fail_co    <= dut_co;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder8_bist_ctrl.sv
// Scoreboard bench: stimulus queues expected vectors/results, a monitor pops and compares.
module tb_adder8_bist_ctrl;

  localparam int N0 = 24;
  localparam int S0 = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] obs;
  } vec_t;

  typedef struct {
    int         errs;
    logic       pass;
    logic       fv;
    logic [7:0] fa;
    logic [7:0] fb;
    logic       fci;
    logic [8:0] fobs;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic stuck1 = 1'b0;

  logic [7:0] a0, b0, s0;
  logic       ci0, co0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [8:0] adder_out = 9'd0;

  logic [7:0] a1, b1, s1;
  logic       ci1, co1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [8:0] sum1;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fv0, fci0, fco0, fv1, fci1, fco1;
  logic [7:0] fa0, fb0, fs0, fa1, fb1, fs1;
`endif

  int   errors = 0;
  int   checks = 0;
  bit   abort_run = 1'b0;
  bit   in_run = 1'b0;
  int   mon_c = 0;
  vec_t vq[$];
  res_t rq[$];

  always #5 clk = ~clk;

  assign {co0, s0} = adder_out;
  assign sum1 = {1'b0, a1} + {1'b0, b1} + {8'd0, ci1};
  assign {co1, s1} = stuck1 ? (sum1 & 9'h1FE) : sum1;

  adder8_bist_ctrl #(.NUM_VECTORS(N0), .SEED(17'h1_0A05), .SETTLE_CYCLES(S0), .ERR_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(a0), .dut_b(b0), .dut_ci(ci0), .dut_s(s0), .dut_co(co0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_ci(fci0), .fail_s(fs0), .fail_co(fco0)
`endif
  );

  adder8_bist_ctrl #(.NUM_VECTORS(1), .SEED(17'h0_0000), .SETTLE_CYCLES(0), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_ci(ci1), .dut_s(s1), .dut_co(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_ci(fci1), .fail_s(fs1), .fail_co(fco1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: vector k appears on dut_* at busy-cycle 1 + k*(S0+2); result when busy drops.
  initial begin
    forever begin
      @(negedge clk);
      if (busy0 && !in_run) begin
        in_run = 1'b1;
        mon_c = 0;
      end
      if (in_run) begin
        if (busy0) begin
          if (mon_c >= 1 && ((mon_c - 1) % (S0 + 2)) == 0) begin
            if (vq.size() == 0) begin
              chk("vec_queue_empty", 32'd1, 32'd0);
            end else begin
              vec_t v;
              v = vq.pop_front();
              chk("vector_abci", {15'd0, a0, b0, ci0}, {15'd0, v.a, v.b, v.ci});
              adder_out = v.obs;
            end
          end
          mon_c++;
        end else begin
          in_run = 1'b0;
          if (abort_run) begin
            abort_run = 1'b0;
          end else if (rq.size() == 0) begin
            chk("res_queue_empty", 32'd1, 32'd0);
          end else begin
            res_t r;
            r = rq.pop_front();
            chk("run_cycles", mon_c, N0 * (S0 + 2));
            chk("done", {31'd0, done0}, 32'd1);
            chk("err_count", {28'd0, err0}, r.errs);
            chk("pass", {31'd0, pass0}, {31'd0, r.pass});
            chk("vec_queue_drained", vq.size(), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
            chk("fail_valid", {31'd0, fv0}, {31'd0, r.fv});
            chk("fail_abci", {15'd0, fa0, fb0, fci0}, {15'd0, r.fa, r.fb, r.fci});
            chk("fail_cos", {23'd0, fco0, fs0}, {23'd0, r.fobs});
`endif
          end
        end
      end
    end
  end

  // Reference: expected operands come from the LFSR recurrence; mode picks the adder behaviour.
  task automatic run_u0(input int mode, input bit extra_start, input bit abort_mid);
    logic [16:0] lf;
    logic [8:0]  sum;
    vec_t        v;
    res_t        r;
    int          e;
    lf = 17'h1_0A05;
    e = 0;
    r = '{errs: 0, pass: 1'b0, fv: 1'b0, fa: 8'd0, fb: 8'd0, fci: 1'b0, fobs: 9'd0};
    for (int k = 0; k < N0; k++) begin
      v.a  = lf[7:0];
      v.b  = lf[15:8];
      v.ci = lf[16];
      sum  = 9'(int'(v.a) + int'(v.b) + int'(v.ci));
      case (mode)
        1: v.obs = ($urandom_range(0, 3) == 0) ? (sum ^ 9'(1 << $urandom_range(0, 8))) : sum;
        2: v.obs = 9'h1FF;
        3: v.obs = sum & 9'h1FE;
        default: v.obs = sum;
      endcase
      if (v.obs != sum) begin
        if (e == 0) begin
          r.fv = 1'b1; r.fa = v.a; r.fb = v.b; r.fci = v.ci; r.fobs = v.obs;
        end
        e++;
      end
      vq.push_back(v);
      lf = {lf[15:0], lf[16] ^ lf[13]};
    end
    r.errs = (e > 15) ? 15 : e;
    r.pass = (e == 0);
    if (!abort_mid) rq.push_back(r);
    $display("run mode=%0d extra_start=%0d abort=%0d expected_errs=%0d", mode, extra_start, abort_mid, r.errs);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (abort_mid) begin
      // vector 3 drives on edge 13; edge 14 leaves the controller in WAIT
      repeat (14) @(negedge clk);
      abort_run = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("abort_zero_abci", {15'd0, a0, b0, ci0}, 32'd0);
      chk("abort_zero_flags", {28'd0, busy0, done0, pass0, 1'b0}, 32'd0);
      chk("abort_zero_err", {28'd0, err0}, 32'd0);
      @(negedge clk);
      #1;
      vq.delete();
      rq.delete();
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", {30'd0, busy0, done0}, 32'd0);
    end else begin
      if (extra_start) begin
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      for (int i = 0; i < N0 * (S0 + 2) + 20 && rq.size() != 0; i++) @(negedge clk);
      if (rq.size() != 0) chk("run_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
      chk("done_holds", {31'd0, done0}, 32'd1);
    end
  endtask

  task automatic run_u1(input bit stuck);
    stuck1 = stuck;
    $display("run u1 stuck=%0d", stuck);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    chk("u1_busy_after_drive", {30'd0, busy1, done1}, 32'd2);
    @(negedge clk);
    chk("u1_done", {30'd0, busy1, done1}, 32'd1);
    chk("u1_abci_seed_forced", {15'd0, a1, b1, ci1}, {15'd0, 8'd1, 8'd0, 1'b0});
    chk("u1_err", {24'd0, err1}, stuck ? 32'd1 : 32'd0);
    chk("u1_pass", {31'd0, pass1}, stuck ? 32'd0 : 32'd1);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("u1_fail_valid", {31'd0, fv1}, {31'd0, stuck});
    chk("u1_fail_a", {24'd0, fa1}, stuck ? 32'd1 : 32'd0);
    chk("u1_fail_s", {24'd0, fs1}, 32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_abci", {15'd0, a0, b0, ci0}, 32'd0);
    chk("reset_flags", {29'd0, busy0, done0, pass0}, 32'd0);
    chk("reset_err", {28'd0, err0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {30'd0, busy0, done0}, 32'd0);

    run_u0(0, 1'b0, 1'b0);
    run_u0(1, 1'b0, 1'b0);
    run_u0(2, 1'b0, 1'b0);
    run_u0(0, 1'b1, 1'b0);
    run_u0(3, 1'b0, 1'b0);
    run_u0(1, 1'b1, 1'b0);
    run_u0(0, 1'b0, 1'b1);
    run_u0(1, 1'b0, 1'b0);
    run_u0(0, 1'b0, 1'b0);

    run_u1(1'b0);
    run_u1(1'b1);
    run_u1(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
